muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with HI/LO result registers for the pipelined MIPS core. It sits beside the Execute stage and accepts one operation per `start` pulse from the E-stage instruction. It raises `busy` for a configurable number of cycles, during which the stall controller holds any HI/LO-using instruction in D. Results land in HI/LO atomically on the last busy cycle.

---
 rtl/muldiv_if.sv | 12 +
 rtl/muldiv_unit.sv | 101 ++++++++++
 tb/tb_muldiv_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: operation request and HI/LO result bundle between the E stage and muldiv_unit.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO writes.
// The divider and DIV state exist only when MULDIV_DIV_EN is defined; otherwise DIV/DIVU are no-ops.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);
  localparam int MAX_LAT = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
  localparam int CW = $clog2(MAX_LAT + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
`ifdef MULDIV_DIV_EN
  localparam logic [1:0] DIV  = 2'd2;
`endif
  logic [1:0]         state;
  logic [1:0]         launch_state;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      launch_lat;
  logic [WIDTH-1:0]   hi, lo, opa, opb;
  logic               sgn;
  logic               idle, go_mul, go_div, go_mt, done;
  logic [2*WIDTH-1:0] xa, xb, prod;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               res_ok;
  assign idle   = state == IDLE;
  assign go_mul = bus.start & idle & (bus.op[2:1] == 2'b00);
  assign go_mt  = bus.start & idle & (bus.op[2:1] == 2'b10);
  assign done   = !idle && cnt == CW'(1);
  // Operands are sign- or zero-extended to full width so one multiplier serves both MULT and MULTU.
  assign xa   = sgn ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
  assign xb   = sgn ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
  assign prod = xa * xb;
`ifdef MULDIV_DIV_EN
  logic             na, nb;
  logic [WIDTH-1:0] ma, mb, dvs, dq, dr;
  assign go_div = bus.start & idle & (bus.op[2:1] == 2'b01);
  assign launch_state = go_div ? DIV : MUL;
  assign launch_lat   = go_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
  // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows dividend.
  assign na  = sgn & opa[WIDTH-1];
  assign nb  = sgn & opb[WIDTH-1];
  assign ma  = na ? -opa : opa;
  assign mb  = nb ? -opb : opb;
  assign dvs = (mb == '0) ? WIDTH'(1) : mb;
  assign dq  = ma / dvs;
  assign dr  = ma % dvs;
  always_comb begin
    res_hi = (state == DIV) ? (na ? -dr : dr) : prod[2*WIDTH-1:WIDTH];
    res_lo = (state == DIV) ? ((na ^ nb) ? -dq : dq) : prod[WIDTH-1:0];
    res_ok = (state != DIV) || (opb != '0);
  end
`else
  assign go_div       = 1'b0;
  assign launch_state = MUL;
  assign launch_lat   = CW'(MUL_LAT);
  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    res_ok = 1'b1;
  end
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      opa   <= '0;
      opb   <= '0;
      sgn   <= 1'b0;
    end else begin
      if (go_mul | go_div) begin
        state <= launch_state;
        cnt   <= launch_lat;
        opa   <= bus.a;
        opb   <= bus.b;
        sgn   <= ~bus.op[0];
      end else if (done) begin
        state <= IDLE;
        cnt   <= '0;
        if (res_ok) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end else if (!idle) begin
        cnt <= cnt - CW'(1);
      end
      if (go_mt) begin
        if (bus.op[0]) lo <= bus.a;
        else           hi <= bus.a;
      end
    end
  end
  assign bus.busy = !idle;
  assign bus.hi   = hi;
  assign bus.lo   = lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;
  logic clk;
  logic reset;
  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          bcnt = 0;
  logic [31:0] mh = 0;
  logic [31:0] ml = 0;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask
  // Reference: plain 64-bit arithmetic on the architectural op meaning.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l, output int lat);
    longint          sp, sq, sr;
    longint unsigned up;
    h = mh; l = ml; lat = 0;
    case (op)
      3'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); {h, l} = sp; lat = 5; end
      3'd1: begin up = longint'({32'b0, a}) * longint'({32'b0, b}); {h, l} = up; lat = 5; end
`ifdef MULDIV_DIV_EN
      3'd2: begin
        lat = 10;
        if (b != 0) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          l = sq[31:0]; h = sr[31:0];
        end
      end
      3'd3: begin
        lat = 10;
        if (b != 0) begin l = a / b; h = a % b; end
      end
`endif
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      else if (bcnt > 0) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("hi", bus.hi, e.hi);
          chk("lo", bus.lo, e.lo);
          chk("busy_cycles", bcnt, e.lat);
        end
        bcnt = 0;
      end
    end
  end
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
    logic [31:0] h, l;
    int          lat;
    @(negedge clk);
    bus.start = 1; bus.op = op; bus.a = a; bus.b = b;
    model(op, a, b, h, l, lat);
    if (lat > 0) sb.push_back('{h, l, lat});
    @(posedge clk);
    #1 bus.start = 0; bus.a = $urandom; bus.b = $urandom;
    if (lat == 0) begin
      chk("imm_busy", bus.busy, 0);
      chk("imm_hi", bus.hi, h);
      chk("imm_lo", bus.lo, l);
    end else begin
      if (inject) begin
        @(negedge clk);
        bus.start = 1; bus.op = 3'd5; bus.a = $urandom;
        @(posedge clk);
        #1 bus.start = 0;
      end
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      chk("timeout", sb.size(), 0);
      sb.delete();
    end
    mh = h; ml = l;
  endtask
  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    reset = 0; bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    @(negedge clk) reset = 1;
    do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd2, -32'sd7, 32'd2, 0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'd4, 32'h1234, 32'd0, 0);
    do_op(3'd3, 32'd5, 32'd0, 1);
    do_op(3'd1, 32'd6, 32'd7, 1);
    do_op(3'd6, 32'hDEAD, 32'd1, 0);
    // Abort a MULT in its third busy cycle.
    @(negedge clk);
    bus.start = 1; bus.op = 3'd0; bus.a = 32'd100; bus.b = 32'd200;
    @(posedge clk);
    #1 bus.start = 0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 0;
    sb.delete(); bcnt = 0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    mh = 0; ml = 0;
    @(negedge clk) reset = 1;
    do_op(3'd0, 32'd100, 32'hFFFF_FFFF, 0);
    for (int n = 0; n < 60; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom);
      do_op(rop, ra, rb, $urandom_range(0, 3) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
